// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encodings, request payload and the out-of-range error data word.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DATA_W-1:0] DMEM_ERR_DATA = 16'hffff;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_wait_counter.sv
// Wait-state down counter for the data-memory responder.
// Loads a start value, decrements on request and flags zero.
module dmem_wait_counter
    import dmem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             pc_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the core load/store port with a wait-state data RAM.
// One request per transaction; response is a one-cycle pulse WAIT_STATES+1
// cycles after accept. Optional feature macro: DMEM_RANGE_CHECK_EN (flags
// requests whose address has bits set above the RAM index and suppresses them).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              pc_reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              stall
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int unsigned     DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    dmem_state_e r_state;
    dmem_state_e w_next;
    dmem_req_t   r_req;
    dmem_req_t   w_in_req;
    dmem_req_t   w_cur;

    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;
    logic                  w_enter_resp;
    logic                  w_oor;
    logic [DEPTH_LOG2-1:0] w_idx;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    assign w_in_req = '{write: req_write, addr: req_addr, wdata: req_wdata};

    // With zero wait states RESP is entered on the accept edge, so the live request is used.
    assign w_cur = (r_state == DMEM_IDLE) ? w_in_req : r_req;
    assign w_idx = w_cur.addr[DEPTH_LOG2-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    assign w_oor = |w_cur.addr[ADDR_W-1:DEPTH_LOG2];
`else
    logic w_unused_addr;
    assign w_oor         = 1'b0;
    assign w_unused_addr = ^w_cur.addr[ADDR_W-1:DEPTH_LOG2];
`endif

    dmem_wait_counter u_wait_cnt (
        .clk        (clk),
        .pc_reset   (pc_reset),
        .i_load     (w_cnt_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (req_valid) begin
                    w_cnt_load = 1'b1;
                    w_next     = (WAIT_STATES > 0) ? DMEM_WAIT : DMEM_RESP;
                end
            end
            DMEM_WAIT: begin
                if (w_cnt_zero) begin
                    w_next = DMEM_RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DMEM_RESP: w_next = DMEM_IDLE;
            default:   w_next = DMEM_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == DMEM_RESP);

    // Request latch, captured on accept.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_req <= '0;
        end else if ((r_state == DMEM_IDLE) && req_valid) begin
            r_req <= w_in_req;
        end
    end

    // Backing RAM: not cleared by reset; a store commits on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_cur.write && !w_oor && !pc_reset) begin
            r_mem[w_idx] <= w_cur.wdata;
        end
    end

    // Response data: load data, store echo, or the error word; held until the next response.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_rdata <= '0;
        end else if (w_enter_resp) begin
            r_rdata <= w_oor ? DMEM_ERR_DATA : (w_cur.write ? w_cur.wdata : r_mem[w_idx]);
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic r_rsp_err;

    // Out-of-range flag for the response being returned.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            r_rsp_err <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_err <= w_oor;
        end
    end

    assign rsp_err = r_rsp_err;
`endif

    assign req_ready = (r_state == DMEM_IDLE);
    assign rsp_valid = (r_state == DMEM_RESP);
    assign rsp_rdata = r_rdata;
    assign stall     = ((r_state == DMEM_IDLE) && req_valid) || (r_state == DMEM_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a
// word-array memory model; a monitor checks handshake timing and response data.
// A second instance with zero wait states covers the minimum-latency case.
module tb_dmem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        pc_reset;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, stall;
    logic [15:0] rsp_rdata;
    logic        rsp_err_w;

    logic        z_req_valid, z_req_write;
    logic [15:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_stall;
    logic [15:0] z_rsp_rdata;
    logic        z_rsp_err_w;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS)) u_dut (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .stall     (stall)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .rsp_err   (rsp_err_w)
`endif
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .req_valid (z_req_valid),
        .req_write (z_req_write),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_ready (z_req_ready),
        .rsp_valid (z_rsp_valid),
        .rsp_rdata (z_rsp_rdata),
        .stall     (z_stall)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .rsp_err   (z_rsp_err_w)
`endif
    );

`ifndef DMEM_RANGE_CHECK_EN
    assign rsp_err_w   = 1'b0;
    assign z_rsp_err_w = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_mem [256];
    int          cyc      = 0;
    int          last_acc = 0;
    bit          has_acc  = 0;
    bit          mon_en   = 0;
    int          tests    = 0;
    int          failed   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Present one request (called just after a falling edge); returns at the falling edge after accept.
    task automatic xact(input logic wr, input logic [15:0] a, input logic [15:0] d);
        int   n;
        bit   acc;
        int   idx;
        exp_t e;
        n   = 0;
        acc = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!acc) begin
            #1;
            if (req_ready) begin
                acc = 1;
                idx = int'(a) % 256;
`ifdef DMEM_RANGE_CHECK_EN
                e.err = (int'(a) >= 256);
`else
                e.err = 1'b0;
`endif
                if (e.err) e.data = 16'hffff;
                else if (wr) begin
                    m_mem[idx] = d;
                    e.data = d;
                end else e.data = m_mem[idx];
                e.due    = cyc + WS + 1;
                sb.push_back(e);
                last_acc = cyc;
                has_acc  = 1;
            end
            @(negedge clk);
            n++;
            if (!acc && n > 50) begin
                failed++;
                tests++;
                $display("FAIL accept_timeout: req_ready got 0 expected 1 within 50 cycles");
                acc = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: handshake windows from the last accept, and response data from the scoreboard.
    always @(negedge clk) begin
        logic in_wait, in_resp, rdy;
        exp_t e;
        #2;
        if (mon_en) begin
            in_wait = has_acc && (cyc > last_acc) && (cyc <= last_acc + WS);
            in_resp = has_acc && (cyc == last_acc + WS + 1);
            rdy     = !(in_wait || in_resp);
            chk("req_ready", 16'(req_ready), 16'(rdy));
            chk("rsp_valid", 16'(rsp_valid), 16'(in_resp));
            chk("stall", 16'(stall), 16'((req_valid && rdy) || in_wait));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 16'(1), 16'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_cycle", 16'(cyc), 16'(e.due));
`ifdef DMEM_RANGE_CHECK_EN
                    chk("rsp_err", 16'(rsp_err_w), 16'(e.err));
`endif
                end
            end
        end
    end

    initial begin
        logic [15:0] old;
        logic        wr;
        logic [15:0] a;
        pc_reset  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        z_req_valid = 1'b0;
        z_req_write = 1'b0;
        z_req_addr  = '0;
        z_req_wdata = '0;

        repeat (3) @(negedge clk);
        pc_reset = 1'b0;
        #2;
        chk("reset_ready", 16'(req_ready), 16'(1));
        chk("reset_rsp_valid", 16'(rsp_valid), 16'(0));
        chk("reset_stall", 16'(stall), 16'(0));
        chk("reset_rdata", rsp_rdata, 16'h0000);
`ifdef DMEM_RANGE_CHECK_EN
        chk("reset_err", 16'(rsp_err_w), 16'(0));
`endif
        @(negedge clk);
        mon_en = 1;

        // Fill the RAM so every later load has a known expectation.
        for (int i = 0; i < 256; i++) begin
            xact(1'b1, 16'(i), 16'($urandom));
        end
        idle(WS + 2);

        // Reset pulse in the middle of WAIT discards the pending store.
        old = m_mem[8'h20];
        xact(1'b1, 16'h0020, 16'h7777);
        req_valid = 1'b0;
        #3;
        mon_en = 0;
        pc_reset = 1'b1;
        #1;
        pc_reset = 1'b0;
        sb.delete();
        has_acc = 0;
        m_mem[8'h20] = old;
        @(negedge clk);
        #3;
        chk("midreset_ready", 16'(req_ready), 16'(1));
        chk("midreset_rsp_valid", 16'(rsp_valid), 16'(0));
        chk("midreset_stall", 16'(stall), 16'(0));
        chk("midreset_rdata", rsp_rdata, 16'h0000);
        mon_en = 1;
        @(negedge clk);
        xact(1'b0, 16'h0020, 16'h0000);
        idle(1);

        // Store then load of the same word.
        xact(1'b1, 16'h0010, 16'hBEEF);
        idle(1);
        xact(1'b0, 16'h0010, 16'h0000);
        // Back-to-back loads with valid held high.
        xact(1'b0, 16'h0011, 16'h0000);
        xact(1'b0, 16'h0012, 16'h0000);
        idle(2);

        // Upper address bits: alias, or flagged out of range.
        xact(1'b1, 16'h0105, 16'h1234);
        xact(1'b0, 16'h0005, 16'h0000);
        idle(1);

        // Randomized mix of loads and stores, gaps and back-to-back.
        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            xact(wr, a, 16'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(WS + 3);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: pending responses got %0d expected 0", sb.size());
        end

        // Zero-wait-state instance: response one cycle after accept, stall only in the accept cycle.
        z_req_valid = 1'b1;
        z_req_write = 1'b1;
        z_req_addr  = 16'h0003;
        z_req_wdata = 16'hA5A5;
        #1;
        chk("z_st_ready", 16'(z_req_ready), 16'(1));
        chk("z_st_stall", 16'(z_stall), 16'(1));
        chk("z_st_rsp_pre", 16'(z_rsp_valid), 16'(0));
        @(negedge clk);
        z_req_valid = 1'b0;
        #1;
        chk("z_st_rsp", 16'(z_rsp_valid), 16'(1));
        chk("z_st_rdata", z_rsp_rdata, 16'hA5A5);
        chk("z_st_stall_resp", 16'(z_stall), 16'(0));
        chk("z_st_ready_resp", 16'(z_req_ready), 16'(0));
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_write = 1'b0;
        #1;
        chk("z_ld_stall", 16'(z_stall), 16'(1));
        chk("z_ld_rsp_pre", 16'(z_rsp_valid), 16'(0));
        @(negedge clk);
        z_req_valid = 1'b0;
        #1;
        chk("z_ld_rsp", 16'(z_rsp_valid), 16'(1));
        chk("z_ld_rdata", z_rsp_rdata, 16'hA5A5);
        chk("z_ld_stall_resp", 16'(z_stall), 16'(0));
        @(negedge clk);
        #1;
        chk("z_idle_rsp", 16'(z_rsp_valid), 16'(0));
        chk("z_idle_stall", 16'(z_stall), 16'(0));
        chk("z_idle_ready", 16'(z_req_ready), 16'(1));
        chk("z_hold_rdata", z_rsp_rdata, 16'hA5A5);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
